crc16_frame_appender: RTL and testbench

//  Byte-stream framer that sequences a CRC-16 (poly 0x1021, x^16+x^12+x^5+1) byte engine over each frame.

---
 rtl/crc16_frame_appender.sv | 182 ++++++++++++++++++
 tb/tb_crc16_frame_appender.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/crc16_frame_appender.sv
// Byte-stream framer: passes payload through and appends CRC-16 (0x1021, MSB first) per frame.
// Optional CRC16_FRAME_CNT_EN adds a frame_cnt output counting completed output frames.
module crc16_frame_appender #(
  parameter logic [15:0] INIT       = 16'hFFFF,
  parameter logic [15:0] OUTPUT_XOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        append_en,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
`ifdef CRC16_FRAME_CNT_EN
  output logic [15:0] crc_value,
  output logic [15:0] frame_cnt
`else
  output logic [15:0] crc_value
`endif
);

  localparam logic [15:0] POLY = 16'h1021;

  typedef enum logic [1:0] {
    PASS   = 2'b00,
    CRC_HI = 2'b01,
    CRC_LO = 2'b10
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [15:0] crc_r, crc_nxt_s;
  logic [15:0] crc_value_r, crc_value_nxt_s;
  logic [7:0]  m_data_r, m_data_nxt_s;
  logic        m_valid_r, m_valid_nxt_s;
  logic        m_last_r, m_last_nxt_s;
  logic        sof_r, sof_nxt_s;
  logic        app_r, app_nxt_s;
  logic        load_ok_s;
  logic        app_eff_s;
  logic        s_ready_s;
  logic [15:0] fcs_s;

  // Eight serial MSB-first steps of the 0x1021 LFSR folded into one byte update.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    logic [7:0]  d;
    logic        fb;
    c = crc;
    d = data;
    for (int k = 0; k < 8; k++) begin
      fb = c[15] ^ d[7];
      c  = {c[14:0], 1'b0} ^ (fb ? POLY : 16'h0000);
      d  = {d[6:0], 1'b0};
    end
    return c;
  endfunction

  assign load_ok_s = !m_valid_r || m_ready;
  assign app_eff_s = sof_r ? append_en : app_r;
  assign fcs_s     = crc_r ^ OUTPUT_XOR;

  // Next-state and next-register values for the framer FSM and output stage.
  always_comb begin
    state_nxt_s     = state_r;
    crc_nxt_s       = crc_r;
    crc_value_nxt_s = crc_value_r;
    m_data_nxt_s    = m_data_r;
    m_valid_nxt_s   = m_valid_r;
    m_last_nxt_s    = m_last_r;
    sof_nxt_s       = sof_r;
    app_nxt_s       = app_r;
    s_ready_s       = 1'b0;
    case (state_r)
      PASS: begin
        s_ready_s = load_ok_s;
        if (s_valid && load_ok_s) begin
          m_data_nxt_s  = s_data;
          m_valid_nxt_s = 1'b1;
          crc_nxt_s     = crc16_next(crc_r, s_data);
          if (sof_r) begin
            app_nxt_s = append_en;
            sof_nxt_s = 1'b0;
          end else begin
            app_nxt_s = app_r;
          end
          if (s_last && app_eff_s) begin
            m_last_nxt_s = 1'b0;
            state_nxt_s  = CRC_HI;
          end else if (s_last) begin
            // Pass-through frame ends here; re-arm for the next frame.
            m_last_nxt_s = 1'b1;
            crc_nxt_s    = INIT;
            sof_nxt_s    = 1'b1;
          end else begin
            m_last_nxt_s = 1'b0;
          end
        end else if (m_ready) begin
          m_valid_nxt_s = 1'b0;
        end else begin
          m_valid_nxt_s = m_valid_r;
        end
      end
      CRC_HI: begin
        if (load_ok_s) begin
          m_data_nxt_s  = fcs_s[15:8];
          m_valid_nxt_s = 1'b1;
          m_last_nxt_s  = 1'b0;
          state_nxt_s   = CRC_LO;
        end else begin
          state_nxt_s = CRC_HI;
        end
      end
      CRC_LO: begin
        if (load_ok_s) begin
          m_data_nxt_s    = fcs_s[7:0];
          m_valid_nxt_s   = 1'b1;
          m_last_nxt_s    = 1'b1;
          crc_value_nxt_s = fcs_s;
          crc_nxt_s       = INIT;
          sof_nxt_s       = 1'b1;
          state_nxt_s     = PASS;
        end else begin
          state_nxt_s = CRC_LO;
        end
      end
      default: begin
        state_nxt_s = PASS;
      end
    endcase
  end

  // State, CRC accumulator and registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= PASS;
      crc_r       <= INIT;
      crc_value_r <= 16'h0000;
      m_data_r    <= 8'h00;
      m_valid_r   <= 1'b0;
      m_last_r    <= 1'b0;
      sof_r       <= 1'b1;
      app_r       <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      crc_r       <= crc_nxt_s;
      crc_value_r <= crc_value_nxt_s;
      m_data_r    <= m_data_nxt_s;
      m_valid_r   <= m_valid_nxt_s;
      m_last_r    <= m_last_nxt_s;
      sof_r       <= sof_nxt_s;
      app_r       <= app_nxt_s;
    end
  end

  assign s_ready   = s_ready_s;
  assign m_data    = m_data_r;
  assign m_valid   = m_valid_r;
  assign m_last    = m_last_r;
  assign crc_value = crc_value_r;

`ifdef CRC16_FRAME_CNT_EN
  logic [15:0] frame_cnt_r;

  // Counts output beats carrying m_last that the sink accepts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'h0000;
    end else if (m_valid_r && m_ready && m_last_r) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end else begin
      frame_cnt_r <= frame_cnt_r;
    end
  end

  assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_crc16_frame_appender.sv
// Self-checking bench for crc16_frame_appender: directed vectors plus random frames and backpressure.
`timescale 1ns/1ps
module tb_crc16_frame_appender;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       append_en;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_last;
  logic       m_ready;

  logic       s_ready, m_valid, m_last;
  logic [7:0] m_data;
  logic [15:0] crc_value;
  logic       s_ready_z, m_valid_z, m_last_z;
  logic [7:0] m_data_z;
  logic [15:0] crc_value_z;
`ifdef CRC16_FRAME_CNT_EN
  logic [15:0] frame_cnt, frame_cnt_z;
`endif

  always #5 clk = ~clk;

  crc16_frame_appender #(.INIT(16'hFFFF), .OUTPUT_XOR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .append_en(append_en), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready),
`ifdef CRC16_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .crc_value(crc_value));

  crc16_frame_appender #(.INIT(16'h0000), .OUTPUT_XOR(16'h0000)) dut_z (
    .clk(clk), .rst_n(rst_n), .append_en(append_en), .s_data(s_data), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready_z), .m_data(m_data_z), .m_valid(m_valid_z), .m_last(m_last_z),
    .m_ready(m_ready),
`ifdef CRC16_FRAME_CNT_EN
    .frame_cnt(frame_cnt_z),
`endif
    .crc_value(crc_value_z));

  int          checks = 0;
  int          errors = 0;
  logic [8:0]  exp_q[$];
  logic [7:0]  frame_q[$];
  bit          rand_ready = 1'b0;
  bit          in_crc = 1'b0;
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data;
  logic        prev_last;
  logic [15:0] exp_crc_a = 16'h0000;
  logic [15:0] exp_crc_z = 16'h0000;
  int          cnt_model = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // CRC as polynomial remainder of the augmented message, with init folded into its top 16 bits.
  function automatic logic [15:0] ref_crc(input logic [15:0] init);
    bit          bits[$];
    logic [15:0] r;
    logic        top;
    foreach (frame_q[i]) for (int b = 7; b >= 0; b--) bits.push_back(frame_q[i][b]);
    for (int i = 0; i < 16; i++) bits.push_back(1'b0);
    for (int i = 0; i < 16; i++) bits[i] = bits[i] ^ init[15-i];
    r = 16'h0000;
    foreach (bits[i]) begin
      top = r[15];
      r   = {r[14:0], bits[i]};
      if (top) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      m_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: scoreboard, hold-under-stall and CRC-phase s_ready checks.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", {31'd0, m_valid}, 32'd1);
        chk("hold_data_last", {23'd0, m_last, m_data}, {23'd0, prev_last, prev_data});
      end
      if (in_crc && !m_last) chk("s_ready_crc", {31'd0, s_ready}, 32'd0);
      if (m_valid && m_last) in_crc = 1'b0;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {23'd0, m_last, m_data}, 32'hFFFF_FFFF);
        end else begin
          chk("beat", {23'd0, m_last, m_data}, {23'd0, exp_q.pop_front()});
        end
        if (m_last) cnt_model++;
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  task automatic send_frame(input bit app, input bit toggle);
    int n;
    int t;
    bit acc;
    n = frame_q.size();
    for (int i = 0; i < n; i++) exp_q.push_back({(!app && i == n - 1), frame_q[i]});
    if (app) begin
      exp_crc_a = ref_crc(16'hFFFF);
      exp_crc_z = ref_crc(16'h0000);
      exp_q.push_back({1'b0, exp_crc_a[15:8]});
      exp_q.push_back({1'b1, exp_crc_a[7:0]});
    end
    for (int i = 0; i < n; i++) begin
      s_data    = frame_q[i];
      s_valid   = 1'b1;
      s_last    = (i == n - 1);
      append_en = (i == 0 || !toggle) ? app : 1'($urandom_range(0, 1));
      t = 0;
      acc = 1'b0;
      while (!acc && t < 300) begin
        @(negedge clk);
        acc = s_ready;
        @(posedge clk);
        #1;
        t++;
      end
      if (!acc) chk("accept_timeout", 32'd0, 32'd1);
      if (app && i == n - 1) in_crc = 1'b1;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic drain_and_check(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || m_valid) && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_drain"}, {31'd0, (exp_q.size() == 0 && !m_valid)}, 32'd1);
    chk({tag, "_crc_value"}, {16'd0, crc_value}, {16'd0, exp_crc_a});
    chk({tag, "_crc_value_init0"}, {16'd0, crc_value_z}, {16'd0, exp_crc_z});
`ifdef CRC16_FRAME_CNT_EN
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, cnt_model);
`endif
    @(posedge clk);
    #1;
  endtask

  task automatic load_123456789();
    frame_q.delete();
    for (int i = 0; i < 9; i++) frame_q.push_back(8'h31 + 8'(i));
  endtask

  initial begin
    bit app;
    int n;
    rst_n = 1'b0; append_en = 1'b0; s_data = 8'h00; s_valid = 1'b0; s_last = 1'b0;
    #12;
    chk("rst_m_valid", {31'd0, m_valid}, 32'd0);
    chk("rst_m_last", {31'd0, m_last}, 32'd0);
    chk("rst_m_data", {24'd0, m_data}, 32'd0);
    chk("rst_crc_value", {16'd0, crc_value}, 32'd0);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef CRC16_FRAME_CNT_EN
    chk("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Standard check string, full-rate sink.
    load_123456789();
    send_frame(1'b1, 1'b0);
    drain_and_check("t1");
    chk("t1_vector", {16'd0, crc_value}, 32'h29B1);
    chk("t2_vector_init0", {16'd0, crc_value_z}, 32'h31C3);

    // One-byte frames back to back.
    frame_q.delete(); frame_q.push_back(8'h00);
    send_frame(1'b1, 1'b0);
    send_frame(1'b1, 1'b0);
    drain_and_check("t3");
    chk("t3_vector", {16'd0, crc_value}, 32'hE1F0);

    // Same string under random backpressure.
    rand_ready = 1'b1;
    load_123456789();
    send_frame(1'b1, 1'b0);
    drain_and_check("t4");
    chk("t4_vector", {16'd0, crc_value}, 32'h29B1);

    // Pass-through frame with append_en toggling mid-frame.
    frame_q.delete(); frame_q.push_back(8'hAA); frame_q.push_back(8'hBB); frame_q.push_back(8'hCC);
    send_frame(1'b0, 1'b1);
    drain_and_check("t5");

    // Random frames, random append, random append_en noise, random backpressure.
    for (int f = 0; f < 14; f++) begin
      n = $urandom_range(1, 16);
      frame_q.delete();
      for (int i = 0; i < n; i++) frame_q.push_back(8'($urandom_range(0, 255)));
      app = 1'($urandom_range(0, 1));
      rand_ready = 1'($urandom_range(0, 1));
      send_frame(app, 1'b1);
      drain_and_check("rand");
    end

    // Async reset while the CRC high byte is pending.
    rand_ready = 1'b0;
    #20;
    load_123456789();
    send_frame(1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_m_valid", {31'd0, m_valid}, 32'd0);
    chk("t6_async_crc_value", {16'd0, crc_value}, 32'd0);
    chk("t6_async_s_ready", {31'd0, s_ready}, 32'd1);
`ifdef CRC16_FRAME_CNT_EN
    chk("t6_async_frame_cnt", {16'd0, frame_cnt}, 32'd0);
`endif
    exp_q.delete();
    in_crc = 1'b0;
    cnt_model = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t6_post_rst_m_valid", {31'd0, m_valid}, 32'd0);
    load_123456789();
    send_frame(1'b1, 1'b0);
    drain_and_check("t6");
    chk("t6_vector", {16'd0, crc_value}, 32'h29B1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
